// File: rtl/card_disp_pkg.sv
// card_disp_pkg: shared types and constants for the card display bank.
//   - chan_state_e : per-channel display state
//   - GLYPH_*      : active-low seven-segment patterns, order {g,f,e,d,c,b,a}
//   - CARD_MIN/MAX : legal card range (Ace..King)
//   - card_valid() : range check used on load
package card_disp_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_REVEAL = 2'd1,
    ST_SHOW   = 2'd2
  } chan_state_e;

  localparam logic [3:0] CARD_MIN = 4'd1;
  localparam logic [3:0] CARD_MAX = 4'd13;

  localparam logic [6:0] BLANK     = 7'b1111111;
  localparam logic [6:0] GLYPH_0   = BLANK;       // no card held
  localparam logic [6:0] GLYPH_1   = 7'b0001000;  // A
  localparam logic [6:0] GLYPH_2   = 7'b0100100;
  localparam logic [6:0] GLYPH_3   = 7'b0110000;
  localparam logic [6:0] GLYPH_4   = 7'b0011001;
  localparam logic [6:0] GLYPH_5   = 7'b0010010;
  localparam logic [6:0] GLYPH_6   = 7'b0000010;
  localparam logic [6:0] GLYPH_7   = 7'b1111000;
  localparam logic [6:0] GLYPH_8   = 7'b0000000;
  localparam logic [6:0] GLYPH_9   = 7'b0010000;
  localparam logic [6:0] GLYPH_10  = 7'b1000000;  // shown as "0"
  localparam logic [6:0] GLYPH_11  = 7'b1100001;  // J
  localparam logic [6:0] GLYPH_12  = 7'b0011000;  // Q
  localparam logic [6:0] GLYPH_13  = 7'b0001001;  // K

  function automatic logic card_valid(input logic [3:0] c);
    return (c >= CARD_MIN) && (c <= CARD_MAX);
  endfunction

endpackage

// File: rtl/card_seg_rom.sv
// card_seg_rom: combinational card-value to seven-segment decoder.
//   card  in  4  card value (1..13 legal)
//   seg   out 7  active-low glyph {g,f,e,d,c,b,a}; blank for 0/14/15
module card_seg_rom
  import card_disp_pkg::*;
(
  input  logic [3:0] card,
  output logic [6:0] seg
);

  always_comb begin
    seg = BLANK;
    case (card)
      4'd1:    seg = GLYPH_1;
      4'd2:    seg = GLYPH_2;
      4'd3:    seg = GLYPH_3;
      4'd4:    seg = GLYPH_4;
      4'd5:    seg = GLYPH_5;
      4'd6:    seg = GLYPH_6;
      4'd7:    seg = GLYPH_7;
      4'd8:    seg = GLYPH_8;
      4'd9:    seg = GLYPH_9;
      4'd10:   seg = GLYPH_10;
      4'd11:   seg = GLYPH_11;
      4'd12:   seg = GLYPH_12;
      4'd13:   seg = GLYPH_13;
      default: seg = GLYPH_0;
    endcase
  end

endmodule

// File: rtl/card_display_bank.sv
// card_display_bank: NUM_CARDS independent card displays. Each channel
// latches new_card on its load bit, blinks the glyph BLINK_TICKS times
// (REVEAL), then holds it (SHOW). Segment outputs are registered.
//   slow_clock  in   system clock, rising edge
//   resetb      in   async active-low reset
//   load        in   per-channel load strobe (level, sampled each edge)
//   new_card    in   card value shared by all channels
//   clear       in   sync clear of all channels, wins over load
//   hex_out     out  7 bits per channel, channel i at [7i+6:7i]
//   busy        out  OR of per-channel REVEAL
module card_display_bank
  import card_disp_pkg::*;
#(
  parameter int NUM_CARDS   = 3,
  parameter int BLINK_TICKS = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                   slow_clock,
  input  logic                   resetb,
  input  logic [NUM_CARDS-1:0]   load,
  input  logic [3:0]             new_card,
  input  logic                   clear,
  output logic [7*NUM_CARDS-1:0] hex_out,
  output logic                   busy
);

  localparam int              CNT_W     = $clog2(2*BLINK_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*BLINK_TICKS-1);
  localparam logic [6:0]      OUT_BLANK = (ACTIVE_LOW != 0) ? BLANK : ~BLANK;

  logic [NUM_CARDS-1:0] in_reveal;

  assign busy = |in_reveal;

  for (genvar g = 0; g < NUM_CARDS; g++) begin : g_chan
    chan_state_e      state_q, state_nx;
    logic [3:0]       card_q, card_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [6:0]       glyph, seg_d, hex_q;

    always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
        state_q <= ST_EMPTY;
        card_q  <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_nx;
        card_q  <= card_nx;
        cnt_q   <= cnt_nx;
      end
    end

    always_comb begin
      state_nx = state_q;
      card_nx  = card_q;
      cnt_nx   = cnt_q;
      if (clear) begin
        state_nx = ST_EMPTY;
        card_nx  = '0;
        cnt_nx   = '0;
      end else if (load[g]) begin
        // Load restarts from any state, including mid-REVEAL.
        cnt_nx = '0;
        if (card_valid(new_card)) begin
          state_nx = ST_REVEAL;
          card_nx  = new_card;
        end else begin
          state_nx = ST_EMPTY;
          card_nx  = '0;
        end
      end else begin
        case (state_q)
          ST_REVEAL: begin
            if (cnt_q == CNT_LAST) begin
              state_nx = ST_SHOW;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end

    card_seg_rom u_rom (
      .card (card_q),
      .seg  (glyph)
    );

    // Even counter frames show the glyph, odd frames are blank.
    always_comb begin
      seg_d = BLANK;
      case (state_q)
        ST_SHOW:   seg_d = glyph;
        ST_REVEAL: seg_d = cnt_q[0] ? BLANK : glyph;
        default:   seg_d = BLANK;
      endcase
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) hex_q <= OUT_BLANK;
      else         hex_q <= (ACTIVE_LOW != 0) ? seg_d : ~seg_d;
    end

    assign in_reveal[g]      = (state_q == ST_REVEAL);
    assign hex_out[7*g +: 7] = hex_q;
  end

endmodule

// File: doc/card_display_bank.md
# card_display_bank

Parametrised bank of NUM_CARDS card-value seven-segment displays for the baccarat datapath. Each channel latches a 4-bit card value (1 = Ace … 13 = King) on a per-channel load strobe and plays a short blink "reveal" sequence. It then holds the glyph steady until the next load or clear. All segment outputs are registered, so the HEX pins never glitch.

## Interface
Parameters:
- NUM_CARDS, default 3: number of display channels (1..8).
- BLINK_TICKS, default 4: number of on/off blink pairs in a reveal (1..15).
- ACTIVE_LOW, default 1: 1 = segment lit when 0 (DE-series HEX); 0 = all segment outputs inverted.

Ports:
- slow_clock  in  1  single system clock; all state updates on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- load  in  NUM_CARDS  per-channel load strobe, sampled each edge.
- new_card  in  4  card value, shared by all channels; written to every channel whose load bit is 1.
- clear  in  1  synchronous clear of all channels.
- hex_out  out  7*NUM_CARDS  segments; channel i at bits [7i+6:7i], order {g,f,e,d,c,b,a}.
- busy  out  1  1 while any channel is in REVEAL.

## Operation
- Each channel has a state in {EMPTY, REVEAL, SHOW}, a 4-bit card register, and a counter of width clog2(2*BLINK_TICKS).
- Glyphs (ACTIVE_LOW = 1):
  - 1 = A 0001000; 2 = 0100100; 3 = 0110000; 4 = 0011001; 5 = 0010010; 6 = 0000010; 7 = 1111000.
  - 8 = 0000000; 9 = 0010000; 10 = "0" 1000000; 11 = J 1100001; 12 = Q 0011000; 13 = K 0001001.
  - Blank = 1111111.
- Load with a valid card (1..13): the card register takes new_card, the counter goes to 0, and the state goes to REVEAL. This applies from any state, so a reload mid-REVEAL restarts the reveal.
- Load with an invalid card (0, 14 or 15): the card register goes to 0 and the state goes to EMPTY.
- REVEAL display rule:
  - Glyph is shown when the counter is even; blank when it is odd.
  - The counter increments every cycle.
  - On the cycle the counter equals 2*BLINK_TICKS−1, the next state is SHOW and the counter goes to 0.
- SHOW: the glyph is displayed steadily.
- EMPTY: the display is blank.
- clear = 1: every channel goes to EMPTY, and card registers and counters go to 0. clear has priority over load in the same cycle.
- Channels are fully independent. Several load bits may be set at once, and each set channel takes the same new_card.
- ACTIVE_LOW = 0: every hex_out bit is the complement of the table above, including blank = 0000000.
- busy is combinational: the OR over channels of (state == REVEAL).

## Timing
- Reset (resetb = 0, asynchronous):
  - All states EMPTY; card registers and counters 0.
  - hex_out all blank (all 1s if ACTIVE_LOW = 1, else all 0s); busy = 0.
- Reset mid-REVEAL aborts the reveal immediately.
- Load sampled at edge k:
  - The state update is visible after edge k.
  - hex_out shows the first glyph frame after edge k+1, because the output is registered from the next-edge decode of the state.
- Reveal length and latency:
  - The reveal occupies exactly 2*BLINK_TICKS cycles of REVEAL.
  - A steady glyph appears from edge k+2*BLINK_TICKS+1 onward.
  - busy falls after edge k+2*BLINK_TICKS, one cycle before the output settles.
- clear at edge k: hex_out is blank after edge k+1.
- No handshake: load is a level sampled every edge. Holding load high re-triggers the reveal every cycle, so the display shows a steady glyph and busy stays 1.

## Structure
- Package card_disp_pkg holds:
  - the channel state enum;
  - the 14 glyph constants and the BLANK constant;
  - the CARD_MIN = 1 and CARD_MAX = 13 constants.
- Sub-module card_seg_rom is purely combinational: 4-bit card in, 7-bit active-low glyph out, blank for 0/14/15. Instantiate one per channel.
- The top module generates NUM_CARDS channel FSMs and output registers, then applies the ACTIVE_LOW inversion at the output register input.

## Test plan
- Reset, then BLINK_TICKS = 2, NUM_CARDS = 3, load = 001, new_card = 12 at edge 0:
  - hex_out[6:0] sequence after edges 1..5 is 0011000, 1111111, 0011000, 1111111, 0011000, then steady.
  - busy is 1 after edges 0..3 and 0 after edge 4.
  - Channels 1 and 2 stay 1111111.
- Reload mid-reveal: load channel 0 with 7, then with 3 two cycles later. The reveal restarts at counter 0 with glyph 0110000, and the full 2*BLINK_TICKS reveal is observed from the second load.
- Invalid values: load channel 1 with 0, then with 14, then with 15. Channel 1 stays blank, its state is EMPTY, and busy stays 0.
- clear and load asserted in the same cycle, with all channels in SHOW: all channels are blank after the next edge and busy = 0.
- Simultaneous load = 111 with new_card = 1: all three channels blink A (0001000) in lockstep.
- Reset mid-operation: assert resetb = 0 asynchronously mid-REVEAL; hex_out goes blank immediately. Repeat the first scenario with ACTIVE_LOW = 0 and check the outputs are bitwise complements.
